// File: rtl/ps2_scan_receiver_pkg.sv
// ps2_scan_receiver_pkg: shared scan-code constants, FSM states and frame check
package ps2_scan_receiver_pkg;
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam int FRAME_LEN = 11;
  localparam int DATA_BITS = FRAME_LEN - 3;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  function automatic logic frame_ok(input logic [7:0] d, input logic p, input logic s);
    return (^{d, p}) & s;
  endfunction
endpackage

// File: rtl/ps2_scan_receiver_input_filter.sv
// ps2_scan_receiver_input_filter: pin synchronisers, ps2_clk level filter and falling-edge pulse
module ps2_scan_receiver_input_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock27,
  input  logic reset_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_fall,
  output logic data_sync
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] clk_s, dat_s;
  logic [CW-1:0] cnt;
  logic filt, filt_q;
  always_ff @(posedge clock27 or negedge reset_n)
    if (!reset_n) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      cnt <= '0;
      filt <= 1'b1;
      filt_q <= 1'b1;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      filt_q <= filt;
      if (clk_s[1] == filt) cnt <= '0;
      else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= clk_s[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  assign clk_fall = filt_q & ~filt;
  assign data_sync = dat_s[1];
endmodule

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: PS/2 frame deserialiser with E0/F0 prefix stripping and make/break strobes
module ps2_scan_receiver
  import ps2_scan_receiver_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 27000
) (
  input  logic       clock27,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keyDataOut,
  output logic       keyPressed,
  output logic       keyReleased,
  output logic       keyExtended,
  output logic       frameError
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic clk_fall, data_sync, par, ext, brk, timeout;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic [TW-1:0] to_cnt;
  state_t state, state_nxt;
  ps2_scan_receiver_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clock27(clock27), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .clk_fall(clk_fall), .data_sync(data_sync)
  );
  assign timeout = state != IDLE && !clk_fall && to_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock27 or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = timeout ? IDLE :
                !clk_fall ? state :
                state == IDLE ? (data_sync ? IDLE : DATA) :
                state == DATA ? (bit_cnt == 3'(DATA_BITS - 1) ? PARITY : DATA) :
                state == PARITY ? STOP : IDLE;
  end
  always_ff @(posedge clock27 or negedge reset_n)
    if (!reset_n) begin
      shift <= '0;
      bit_cnt <= '0;
      par <= 1'b0;
      to_cnt <= '0;
      ext <= 1'b0;
      brk <= 1'b0;
      keyDataOut <= '0;
      keyPressed <= 1'b0;
      keyReleased <= 1'b0;
      keyExtended <= 1'b0;
      frameError <= 1'b0;
    end else begin
      keyPressed <= 1'b0;
      keyReleased <= 1'b0;
      frameError <= 1'b0;
      to_cnt <= (state == IDLE || clk_fall || timeout) ? '0 : to_cnt + 1'b1;
      if (timeout) begin
        frameError <= 1'b1;
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (clk_fall) begin
        if (state == IDLE) bit_cnt <= '0;
        if (state == DATA) begin
          shift <= {data_sync, shift[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        if (state == PARITY) par <= data_sync;
        if (state == STOP) begin
          if (!frame_ok(shift, par, data_sync)) begin
            frameError <= 1'b1;
            ext <= 1'b0;
            brk <= 1'b0;
          end else if (shift == SC_EXT) ext <= 1'b1;
          else if (shift == SC_BREAK) brk <= 1'b1;
          else begin
            keyDataOut <= shift;
            keyExtended <= ext;
            keyReleased <= brk;
            keyPressed <= ~brk;
            ext <= 1'b0;
            brk <= 1'b0;
          end
        end
      end
    end
endmodule
